// File: rtl/uart_pkg.sv
// Shared definitions for the system-bus UART receiver: FSM states, register
// offsets and divisor limits.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } uart_rx_state_t;

    localparam logic [23:0] UART_DATA   = 24'h00;
    localparam logic [23:0] UART_VALID  = 24'h04;
    localparam logic [23:0] UART_BUSY   = 24'h08;
    localparam logic [23:0] UART_DIV    = 24'h0C;
    localparam logic [23:0] UART_PARITY = 24'h10;
    localparam logic [23:0] UART_STOP   = 24'h14;
    localparam logic [23:0] UART_STATUS = 24'h18;
    localparam logic [23:0] UART_RST    = 24'h24;

    localparam logic [15:0] DEFAULT_DIV = 16'd87;
    localparam logic [15:0] DIV_MIN     = 16'd4;

endpackage

// File: rtl/uart_rx_core.sv
// UART receive engine: input synchroniser, bit-timing counter and frame FSM.
// Reports each finished frame as a one-cycle done_ok or done_err pulse.
module uart_rx_core
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    input  logic        soft_rst,
    input  logic [15:0] div,
    input  logic        parity_en,
    input  logic        stopbits,
    output logic [7:0]  rx_byte,
    output logic        done_ok,
    output logic        done_err,
    output logic        busy
);

    logic [1:0]     rx_sync;
    logic           rx_s;
    uart_rx_state_t state;
    logic [15:0]    cnt;
    logic [2:0]     bitidx;
    logic [7:0]     shreg;
    logic           bad;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s = rx_sync[1];

    // Every sample happens when cnt reaches zero; START waits half a bit so
    // that all later samples land mid-bit. In STOP, bitidx counts stop bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shreg  <= '0;
            bad    <= 1'b0;
        end else if (soft_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shreg  <= '0;
            bad    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= div >> 1;
                        bad   <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (rx_s) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt    <= div - 16'd1;
                        bitidx <= '0;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        shreg  <= {rx_s, shreg[7:1]};
                        cnt    <= div - 16'd1;
                        bitidx <= bitidx + 3'd1;
                        if (bitidx == 3'd7) begin
                            state <= parity_en ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        if (rx_s != ^shreg) begin
                            bad <= 1'b1;
                        end
                        cnt   <= div - 16'd1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        if (!rx_s) begin
                            bad <= 1'b1;
                        end
                        if (stopbits && bitidx == 3'd0) begin
                            bitidx <= 3'd1;
                            cnt    <= div - 16'd1;
                        end else begin
                            bitidx <= '0;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_byte  = shreg;
    assign done_ok  = (state == ST_DONE) && !bad;
    assign done_err = (state == ST_DONE) && bad;
    assign busy     = (state != ST_IDLE);

endmodule

// File: rtl/uart_rx_sb_ctrl.sv
// System-bus UART receiver peripheral: register file, bus decode, receive
// flags and interrupt line around the uart_rx_core engine.
module uart_rx_sb_ctrl
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    input  logic        rx_i,
    output logic        interrupt_request_o,
    input  logic        interrupt_return_i
);

    logic [15:0] div;
    logic        parity_en;
    logic        stopbits;
    logic        valid;
    logic        valid_d;
    logic        err;
    logic        overrun;
    logic [7:0]  data;

    logic [23:0] off;
    logic        is_rd;
    logic        is_wr;
    logic        rd_data_hit;
    logic        rd_status_hit;
    logic        soft_rst;
    logic [31:0] rdata_mux;

    logic [7:0]  rx_byte;
    logic        done_ok;
    logic        done_err;
    logic        busy;
    logic        unused_bits;

    assign off           = addr_i[23:0];
    assign is_rd         = req_i && !write_enable_i;
    assign is_wr         = req_i && write_enable_i;
    assign rd_data_hit   = is_rd && (off == UART_DATA);
    assign rd_status_hit = is_rd && (off == UART_STATUS);
    assign soft_rst      = is_wr && (off == UART_RST) && write_data_i[0];
    assign unused_bits   = ^{addr_i[31:24], write_data_i[31:16]};

    uart_rx_core u_core (
        .clk       (clk_i),
        .resetn    (resetn_i),
        .rx        (rx_i),
        .soft_rst  (soft_rst),
        .div       (div),
        .parity_en (parity_en),
        .stopbits  (stopbits),
        .rx_byte   (rx_byte),
        .done_ok   (done_ok),
        .done_err  (done_err),
        .busy      (busy)
    );

    always_comb begin
        rdata_mux = '0;
        case (off)
            UART_DATA:   rdata_mux = {24'd0, data};
            UART_VALID:  rdata_mux = {31'd0, valid};
            UART_BUSY:   rdata_mux = {31'd0, busy};
            UART_DIV:    rdata_mux = {16'd0, div};
            UART_PARITY: rdata_mux = {31'd0, parity_en};
            UART_STOP:   rdata_mux = {31'd0, stopbits};
            UART_STATUS: rdata_mux = {30'd0, overrun, err};
            default:     rdata_mux = '0;
        endcase
    end

    // A new byte beats a simultaneous data read or interrupt return.
    always_comb begin
        valid_d = valid;
        if (soft_rst) begin
            valid_d = 1'b0;
        end else if (done_ok) begin
            valid_d = 1'b1;
        end else if (rd_data_hit || interrupt_return_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            read_data_o <= '0;
        end else if (is_rd) begin
            read_data_o <= rdata_mux;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            div       <= DEFAULT_DIV;
            parity_en <= 1'b0;
            stopbits  <= 1'b0;
        end else if (is_wr && !busy) begin
            case (off)
                UART_DIV: begin
                    if (write_data_i[15:0] >= DIV_MIN) begin
                        div <= write_data_i[15:0];
                    end
                end
                UART_PARITY: parity_en <= write_data_i[0];
                UART_STOP:   stopbits  <= write_data_i[0];
                default: ;
            endcase
        end
    end

    // A byte read on the same edge it is replaced is not an overrun.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            valid               <= 1'b0;
            interrupt_request_o <= 1'b0;
            err                 <= 1'b0;
            overrun             <= 1'b0;
            data                <= '0;
        end else begin
            valid               <= valid_d;
            interrupt_request_o <= valid_d;
            if (soft_rst) begin
                err     <= 1'b0;
                overrun <= 1'b0;
            end else begin
                if (done_err) begin
                    err <= 1'b1;
                end else if (rd_status_hit) begin
                    err <= 1'b0;
                end
                if (done_ok && valid && !rd_data_hit) begin
                    overrun <= 1'b1;
                end else if (rd_status_hit) begin
                    overrun <= 1'b0;
                end
                if (done_ok) begin
                    data <= rx_byte;
                end
            end
        end
    end

endmodule
